// File: rtl/burst_pkg.sv
// burst_pkg: shared state encoding, widths and LFSR constants for burst_responder.
//   Used by burst_responder (FSM, counters, stall logic) and burst_resp_buf (storage).
package burst_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SINK   = 2'd1,
        ST_SOURCE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int DATA_W = 8;
    localparam int LEN_W  = 8;

    // Fibonacci LFSR, taps 8,6,5,4 -> bits 7,5,4,3
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], ^(l & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/burst_resp_buf.sv
// burst_resp_buf: DEPTH x DATA_W buffer, synchronous write, registered enable-gated read.
//   clk, rst_n       : clock, async active-low reset (read register only; array is not reset)
//   we_i/waddr_i/wdata_i : write port
//   re_i/raddr_i     : read request; rdata_o updates the cycle after re_i and holds otherwise
module burst_resp_buf
    import burst_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int PW    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [PW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [PW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/burst_responder.sv
// burst_responder: far-end peer on the 8-bit valid/ready/last burst interface.
//   cfg_*      : transaction setup, cfg_start sampled only in IDLE
//   s_*        : sink side, beats written to the buffer, last placement checked
//   m_*        : source side, buffer replayed from entry 0 as bursts of cfg_max_burst
//   busy/done  : transaction in progress / one-cycle completion pulse
//   err_last   : sticky last-placement error, rx_count : beats accepted (saturating)
//   Optional: BURST_RESP_STALL_EN adds LFSR-driven ready/valid stalls.
module burst_responder
    import burst_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_start,
    input  logic              cfg_dir,
    input  logic [LEN_W-1:0]  cfg_length,
    input  logic [LEN_W-1:0]  cfg_max_burst,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic              busy,
    output logic              done,
    output logic              err_last,
    output logic [LEN_W-1:0]  rx_count
);

    localparam int PW = (AW > 0) ? AW : 1;

    state_t            state_q;
    logic [LEN_W-1:0]  max_q, rem_q, bcnt_q, rx_q;
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
    logic              s_ready_q, m_valid_q, m_last_q, busy_q, done_q, err_q;
    logic              stall_now, stall_next;
    logic              exp_last, acc, hs, load;

`ifdef BURST_RESP_STALL_EN
    logic [7:0] lfsr_q, lfsr_d;
    assign lfsr_d = lfsr_step(lfsr_q);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= LFSR_SEED;
        else lfsr_q <= lfsr_d;
    end
    assign stall_now  = lfsr_q[0];
    // s_ready is registered, so it follows the bit the LFSR will hold next cycle
    assign stall_next = lfsr_d[0];
`else
    assign stall_now  = 1'b0;
    assign stall_next = 1'b0;
`endif

    assign wr_ptr_d = (DEPTH == 1) ? '0 : wr_ptr_q + PW'(1);
    assign rd_ptr_d = (DEPTH == 1) ? '0 : rd_ptr_q + PW'(1);

    // rem_q counts beats not yet accepted (sink) or not yet loaded (source)
    assign exp_last = ((max_q != '0) && (bcnt_q == max_q - LEN_W'(1))) || (rem_q == LEN_W'(1));
    assign acc      = (state_q == ST_SINK) && s_valid && s_ready_q;
    assign hs       = m_valid_q && m_ready;
    // a new beat is fetched when the output slot is empty or being emptied this cycle;
    // stalls only delay a fresh assertion, never drop a pending beat
    assign load     = (state_q == ST_SOURCE) && (rem_q != '0) && (m_valid_q ? m_ready : ~stall_now);

    burst_resp_buf #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (s_data),
        .re_i    (load),
        .raddr_i (rd_ptr_q),
        .rdata_o (m_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            max_q     <= '0;
            rem_q     <= '0;
            bcnt_q    <= '0;
            rx_q      <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cfg_start) begin
                        max_q    <= cfg_max_burst;
                        rem_q    <= cfg_length;
                        bcnt_q   <= '0;
                        rx_q     <= '0;
                        wr_ptr_q <= '0;
                        rd_ptr_q <= '0;
                        err_q    <= 1'b0;
                        busy_q   <= 1'b1;
                        done_q   <= (cfg_length == '0);
                        state_q  <= (cfg_length == '0) ? ST_DONE : (cfg_dir ? ST_SOURCE : ST_SINK);
                    end
                end
                ST_SINK: begin
                    s_ready_q <= ~(acc && (rem_q == LEN_W'(1))) & ~stall_next;
                    if (acc) begin
                        wr_ptr_q <= wr_ptr_d;
                        rx_q     <= (rx_q == '1) ? rx_q : rx_q + LEN_W'(1);
                        rem_q    <= rem_q - LEN_W'(1);
                        bcnt_q   <= exp_last ? '0 : bcnt_q + LEN_W'(1);
                        if (s_last != exp_last) err_q <= 1'b1;
                        if (rem_q == LEN_W'(1)) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_SOURCE: begin
                    if (load) begin
                        rd_ptr_q  <= rd_ptr_d;
                        rem_q     <= rem_q - LEN_W'(1);
                        bcnt_q    <= exp_last ? '0 : bcnt_q + LEN_W'(1);
                        m_valid_q <= 1'b1;
                        m_last_q  <= exp_last;
                    end else if (hs) begin
                        m_valid_q <= 1'b0;
                        m_last_q  <= 1'b0;
                        if (rem_q == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign s_ready  = s_ready_q;
    assign m_valid  = m_valid_q;
    assign m_last   = m_last_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err_last = err_q;
    assign rx_count = rx_q;

endmodule
